decode_regfile_scoreboard: RTL and testbench

Decode-stage reader of the write-back interface. It holds the 32-entry integer register file and serves two combinational read ports with write-through bypass from the W stage. It also keeps a per-register scoreboard of outstanding loads and raises Stall_D when a decode source operand depends on a load that has not yet reached write-back. It consumes RegWrite_W, ResultSrc_W, Rd_W and Result_W from the write-phase pipeline registers, and issue information from decode.

---
 rtl/decode_regfile_scoreboard.sv | 155 +++++++++++++++
 tb/tb_decode_regfile_scoreboard.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// decode_regfile_scoreboard
//
// Decode-stage register file with a load scoreboard.
//   - Holds the 32 x XLEN integer register file (x0 is hard-wired to zero).
//   - Serves two combinational read ports. A write-back in the same cycle to
//     the register being read is forwarded straight to the read port.
//   - Tracks one "load outstanding" bit per register. Decode stalls when a
//     source operand names a register whose load has not reached write-back.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   reset        asynchronous, active-low; clears registers and scoreboard
//   Rs1_D/Rs2_D  decode source addresses
//   RD1_D/RD2_D  decode source data (combinational, with W-stage bypass)
//   Issue_D      decode wants to advance its instruction to E this cycle
//   Flush_E      the instruction leaving decode is being killed
//   RegWrite_D   decode instruction writes Rd_D
//   ResultSrc_D  decode result source (LOAD_SRC marks a load)
//   Rd_D         decode destination
//   RegWrite_W   write-back enable
//   ResultSrc_W  write-back result source
//   Rd_W         write-back destination
//   Result_W     write-back data
//   Stall_D      decode must hold (combinational)
//   Pending_o    scoreboard vector; bit i set = load to x[i] outstanding
// -----------------------------------------------------------------------------
module decode_regfile_scoreboard #(
  parameter int          XLEN     = 32,
  parameter logic [1:0]  LOAD_SRC = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      Rs1_D,
  input  logic [4:0]      Rs2_D,
  output logic [XLEN-1:0] RD1_D,
  output logic [XLEN-1:0] RD2_D,
  input  logic            Issue_D,
  input  logic            Flush_E,
  input  logic            RegWrite_D,
  input  logic [1:0]      ResultSrc_D,
  input  logic [4:0]      Rd_D,
  input  logic            RegWrite_W,
  input  logic [1:0]      ResultSrc_W,
  input  logic [4:0]      Rd_W,
  input  logic [XLEN-1:0] Result_W,
  output logic            Stall_D,
  output logic [31:0]     Pending_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs [32];
  logic [31:0]     pending;

  // ---------------------------------------------------------------------------
  // Write-back side qualifiers
  // ---------------------------------------------------------------------------
  logic wb_write;      // architectural write this cycle
  logic wb_load_clr;   // a load reaches write-back: retire its pending bit

  assign wb_write    = RegWrite_W && (Rd_W != 5'd0);
  assign wb_load_clr = wb_write && (ResultSrc_W == LOAD_SRC);

  // ---------------------------------------------------------------------------
  // Read ports with write-through bypass
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] rs);
    logic [XLEN-1:0] data;
    if (rs == 5'd0)
      data = '0;
    else if (RegWrite_W && (Rd_W == rs))
      data = Result_W;
    else
      data = regs[rs];
    return data;
  endfunction

  assign RD1_D = read_port(Rs1_D);
  assign RD2_D = read_port(Rs2_D);

  // ---------------------------------------------------------------------------
  // Hazard detection
  // A source that matches the load retiring this cycle is not a hazard: the
  // bypass above delivers the loaded value in the same cycle.
  // ---------------------------------------------------------------------------
  function automatic logic src_hazard(input logic [4:0] rs);
    return (rs != 5'd0) && pending[rs] && !(wb_load_clr && (Rd_W == rs));
  endfunction

  logic hz_1;
  logic hz_2;

  assign hz_1    = src_hazard(Rs1_D);
  assign hz_2    = src_hazard(Rs2_D);
  assign Stall_D = hz_1 || hz_2;

  // ---------------------------------------------------------------------------
  // Scoreboard next state
  // Only an instruction that really leaves decode (not stalled, not flushed)
  // may mark its destination as pending.
  // ---------------------------------------------------------------------------
  logic        iss;
  logic        load_set;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_next;

  assign iss      = Issue_D && !Stall_D && !Flush_E;
  assign load_set = iss && RegWrite_D && (ResultSrc_D == LOAD_SRC) && (Rd_D != 5'd0);

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    set_mask = '0;
    clr_mask = '0;
    if (load_set)
      set_mask[Rd_D] = 1'b1;
    if (wb_load_clr)
      clr_mask[Rd_W] = 1'b1;
    // Clear first, then set: a younger load to the same register wins over
    // the older one retiring in the same cycle.
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // all registers sample their inputs from the same pre-edge values.
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is deliberately reset (flop-based, not a RAM macro):
      // reset must architecturally zero every register, so it cannot map to
      // a memory without a reset port.
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wb_write) begin
      regs[Rd_W] <= Result_W;
    end
  end

  assign Pending_o = pending;

endmodule

// File: tb/tb_decode_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_decode_regfile_scoreboard
//
// Self-checking bench for decode_regfile_scoreboard. A behavioural model
// (plain arrays of register values and outstanding-load flags) is advanced on
// every rising edge and compared against the DUT in the middle of each cycle.
// -----------------------------------------------------------------------------
module tb_decode_regfile_scoreboard;

  localparam int         XLEN = 32;
  localparam logic [1:0] LOAD = 2'b01;

  logic            clk;
  logic            reset;
  logic [4:0]      rs1_d, rs2_d;
  logic [XLEN-1:0] rd1_d, rd2_d;
  logic            issue_d, flush_e, reg_write_d;
  logic [1:0]      result_src_d;
  logic [4:0]      rd_d;
  logic            reg_write_w;
  logic [1:0]      result_src_w;
  logic [4:0]      rd_w;
  logic [XLEN-1:0] result_w;
  logic            stall_d;
  logic [31:0]     pending_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [XLEN-1:0] m_x    [32];
  bit              m_pend [32];

  decode_regfile_scoreboard #(.XLEN(XLEN), .LOAD_SRC(LOAD)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1_D      (rs1_d),
    .Rs2_D      (rs2_d),
    .RD1_D      (rd1_d),
    .RD2_D      (rd2_d),
    .Issue_D    (issue_d),
    .Flush_E    (flush_e),
    .RegWrite_D (reg_write_d),
    .ResultSrc_D(result_src_d),
    .Rd_D       (rd_d),
    .RegWrite_W (reg_write_w),
    .ResultSrc_W(result_src_w),
    .Rd_W       (rd_w),
    .Result_W   (result_w),
    .Stall_D    (stall_d),
    .Pending_o  (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (time=%0t, required < 2000000)", $time);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] m_read(input logic [4:0] rs);
    if (rs == 0) return '0;
    if (reg_write_w && rd_w == rs) return result_w;
    return m_x[rs];
  endfunction

  function automatic bit m_src_wait(input logic [4:0] rs);
    bit retiring;
    retiring = reg_write_w && result_src_w == LOAD && rd_w == rs;
    return rs != 0 && m_pend[rs] && !retiring;
  endfunction

  function automatic bit m_stall();
    return m_src_wait(rs1_d) || m_src_wait(rs2_d);
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_x[i]    = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Advance one clock: update the model with the inputs present at the edge.
  task automatic tick();
    bit iss;
    @(posedge clk);
    iss = issue_d && !m_stall() && !flush_e;
    if (reg_write_w && rd_w != 0) m_x[rd_w] = result_w;
    if (reg_write_w && result_src_w == LOAD && rd_w != 0) m_pend[rd_w] = 1'b0;
    if (iss && reg_write_d && result_src_d == LOAD && rd_d != 0) m_pend[rd_d] = 1'b1;
    #1;
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0;
    issue_d = 0; flush_e = 0; reg_write_d = 0; result_src_d = 0; rd_d = 0;
    reg_write_w = 0; result_src_w = 0; rd_w = 0; result_w = '0;
  endtask

  task automatic drive_w(input logic we, input logic [1:0] src, input logic [4:0] rd,
                         input logic [XLEN-1:0] res);
    reg_write_w = we; result_src_w = src; rd_w = rd; result_w = res;
  endtask

  task automatic drive_d(input logic iss, input logic fl, input logic we,
                         input logic [1:0] src, input logic [4:0] rd);
    issue_d = iss; flush_e = fl; reg_write_d = we; result_src_d = src; rd_d = rd;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Power-on reset: everything reads zero before any edge.
    reset = 1'b0;
    idle();
    rs1_d = 5'd3; rs2_d = 5'd17;
    m_clear();
    #2;
    checks++;
    if (pending_o !== 32'h0) begin
      errors++; $display("FAIL reset_pending: got %h want %h", pending_o, 32'h0);
    end
    checks++;
    if (rd1_d !== '0 || rd2_d !== '0) begin
      errors++; $display("FAIL reset_reads: got %h/%h want 0/0", rd1_d, rd2_d);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    idle();

    // Build Pending = 0x20 and a live register, then reset mid-cycle.
    drive_w(1'b1, 2'b00, 5'd2, 32'h0000_0077);
    drive_d(1'b1, 1'b0, 1'b1, LOAD, 5'd5);
    #1;
    tick();
    idle();
    rs1_d = 5'd2; rs2_d = 5'd5;
    #1;
    checks++;
    if (pending_o !== 32'h0000_0020) begin
      errors++; $display("FAIL reset_pre_pending: got %h want %h", pending_o, 32'h20);
    end
    checks++;
    if (rd1_d !== 32'h77 || stall_d !== 1'b1) begin
      errors++; $display("FAIL reset_pre_state: rd1=%h stall=%b want 77/1", rd1_d, stall_d);
    end
    #1 reset = 1'b0;
    m_clear();
    #1;
    checks++;
    if (pending_o !== 32'h0 || rd1_d !== '0 || rd2_d !== '0 || stall_d !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pend=%h rd1=%h rd2=%h stall=%b want 0/0/0/0",
               pending_o, rd1_d, rd2_d, stall_d);
    end
    // A write presented while reset is held must not be retained.
    drive_w(1'b1, 2'b00, 5'd9, 32'h0000_00AA);
    @(posedge clk); #1;
    reset = 1'b1;
    idle();
    rs1_d = 5'd9;
    #1;
    checks++;
    if (rd1_d !== '0) begin
      errors++; $display("FAIL reset_write_dropped: got %h want 0", rd1_d);
    end
  endtask

  task automatic test_write_bypass();
    idle();
    drive_w(1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF);
    rs1_d = 5'd5;
    #1;
    checks++;
    if (rd1_d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rd1_d);
    end
    tick();
    idle();
    rs1_d = 5'd5;
    #1;
    checks++;
    if (rd1_d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_stored: got %h want deadbeef", rd1_d);
    end
  endtask

  task automatic test_x0();
    logic [31:0] pend_before;
    idle();
    pend_before = pending_o;
    drive_w(1'b1, LOAD, 5'd0, 32'h0000_1234);
    rs1_d = 5'd0;
    #1;
    checks++;
    if (rd1_d !== '0) begin
      errors++; $display("FAIL x0_bypass: got %h want 0", rd1_d);
    end
    tick();
    idle();
    rs1_d = 5'd0;
    #1;
    checks++;
    if (rd1_d !== '0 || pending_o !== pend_before) begin
      errors++;
      $display("FAIL x0_write: rd1=%h pend=%h want 0/%h", rd1_d, pending_o, pend_before);
    end
  endtask

  task automatic test_load_use();
    idle();
    drive_d(1'b1, 1'b0, 1'b1, LOAD, 5'd7);   // lw x7 issues at t
    #1;
    tick();
    for (int c = 1; c <= 2; c++) begin       // t+1, t+2
      idle();
      rs2_d = 5'd7;
      drive_d(1'b1, 1'b0, 1'b0, 2'b00, 5'd0);
      #1;
      checks++;
      if (stall_d !== 1'b1) begin
        errors++; $display("FAIL load_use_stall_t%0d: got %b want 1", c, stall_d);
      end
      tick();
    end
    idle();                                  // t+3: load writes back
    rs2_d = 5'd7;
    drive_d(1'b1, 1'b0, 1'b0, 2'b00, 5'd0);
    drive_w(1'b1, LOAD, 5'd7, 32'h0000_0055);
    #1;
    checks++;
    if (stall_d !== 1'b0 || rd2_d !== 32'h55) begin
      errors++; $display("FAIL load_use_release: stall=%b rd2=%h want 0/55", stall_d, rd2_d);
    end
    tick();
    idle();
    #1;
    checks++;
    if (pending_o[7] !== 1'b0) begin
      errors++; $display("FAIL load_use_clear: got %b want 0", pending_o[7]);
    end
  endtask

  task automatic test_flush_stall_gating();
    logic [31:0] pend_before;
    idle();
    pend_before = pending_o;
    drive_d(1'b1, 1'b1, 1'b1, LOAD, 5'd12);  // flushed load
    #1;
    tick();
    idle();
    #1;
    checks++;
    if (pending_o !== pend_before) begin
      errors++; $display("FAIL flush_no_set: got %h want %h", pending_o, pend_before);
    end
    drive_d(1'b1, 1'b0, 1'b1, LOAD, 5'd9);   // lw x9
    #1;
    tick();
    idle();
    rs1_d = 5'd9;
    drive_d(1'b1, 1'b0, 1'b1, LOAD, 5'd3);   // lw x3, stalled by x9
    #1;
    checks++;
    if (stall_d !== 1'b1) begin
      errors++; $display("FAIL stall_on_x9: got %b want 1", stall_d);
    end
    tick();
    idle();
    #1;
    checks++;
    if (pending_o[3] !== 1'b0 || pending_o[9] !== 1'b1) begin
      errors++;
      $display("FAIL stall_no_set: p3=%b p9=%b want 0/1", pending_o[3], pending_o[9]);
    end
    drive_w(1'b1, LOAD, 5'd9, 32'h0000_0099); // retire x9
    #1;
    tick();
    idle();
    #1;
  endtask

  task automatic test_same_cycle();
    idle();
    drive_d(1'b1, 1'b0, 1'b1, LOAD, 5'd4);   // older lw x4 at t
    #1;
    tick();
    idle(); #1; tick();
    idle(); #1; tick();
    idle();                                  // t+3: older retires, younger issues
    drive_w(1'b1, LOAD, 5'd4, 32'h0000_0044);
    drive_d(1'b1, 1'b0, 1'b1, LOAD, 5'd4);
    #1;
    tick();
    idle();
    #1;
    checks++;
    if (pending_o[4] !== 1'b1) begin
      errors++; $display("FAIL set_wins: got %b want 1", pending_o[4]);
    end
    tick();
    idle(); #1; tick();
    idle();
    drive_w(1'b1, LOAD, 5'd4, 32'h0000_0045); // younger write-back
    #1;
    tick();
    idle();
    rs1_d = 5'd4;
    #1;
    checks++;
    if (pending_o[4] !== 1'b0 || rd1_d !== 32'h45) begin
      errors++;
      $display("FAIL younger_clear: p4=%b rd1=%h want 0/45", pending_o[4], rd1_d);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] exp1, exp2;
    logic [31:0]     exp_pend;
    bit              exp_stall;
    for (int n = 0; n < 400; n++) begin
      rs1_d        = 5'($urandom_range(0, 7));
      rs2_d        = 5'($urandom_range(0, 7));
      issue_d      = 1'($urandom_range(0, 3) != 0);
      flush_e      = 1'($urandom_range(0, 7) == 0);
      reg_write_d  = 1'($urandom_range(0, 3) != 0);
      result_src_d = 2'($urandom_range(0, 2) == 0 ? 0 : 1);
      rd_d         = 5'($urandom_range(0, 7));
      reg_write_w  = 1'($urandom_range(0, 1));
      result_src_w = 2'($urandom_range(0, 3));
      rd_w         = 5'($urandom_range(0, 7));
      result_w     = $urandom;
      #1;
      exp1      = m_read(rs1_d);
      exp2      = m_read(rs2_d);
      exp_stall = m_stall();
      exp_pend  = m_pend_vec();
      checks++;
      if (rd1_d !== exp1 || rd2_d !== exp2) begin
        errors++;
        $display("FAIL rand_read[%0d]: rd1=%h rd2=%h want %h/%h", n, rd1_d, rd2_d, exp1, exp2);
      end
      checks++;
      if (stall_d !== exp_stall) begin
        errors++; $display("FAIL rand_stall[%0d]: got %b want %b", n, stall_d, exp_stall);
      end
      checks++;
      if (pending_o !== exp_pend) begin
        errors++; $display("FAIL rand_pending[%0d]: got %h want %h", n, pending_o, exp_pend);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_x0();
    test_load_use();
    test_flush_stall_gating();
    test_same_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
